// File: rtl/handshake_memory_rw.sv
// handshake_memory_rw: N_ST store / N_LD load elastic ports in front of a small register array.
// Optional feature macro: HANDSHAKE_MEM_BOUNDS_CHECK_EN (drop/zero out-of-range accesses, sticky oob_err).
module handshake_memory_rw #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 4,
  parameter int N_ST   = 5,
  parameter int N_LD   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_ST*DATA_W-1:0]   stData,
  input  logic [N_ST-1:0]          stData_valid,
  output logic [N_ST-1:0]          stData_ready,
  input  logic [N_ST*ADDR_W-1:0]   stAddr,
  input  logic [N_ST-1:0]          stAddr_valid,
  output logic [N_ST-1:0]          stAddr_ready,
  output logic [N_ST-1:0]          stDone_valid,
  input  logic [N_ST-1:0]          stDone_ready,
  input  logic [N_LD*ADDR_W-1:0]   ldAddr,
  input  logic [N_LD-1:0]          ldAddr_valid,
  output logic [N_LD-1:0]          ldAddr_ready,
  output logic [N_LD*DATA_W-1:0]   ldData,
  output logic [N_LD-1:0]          ldData_valid,
  input  logic [N_LD-1:0]          ldData_ready,
  output logic                     oob_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [N_ST-1:0]   st_fire_s;
  logic [N_ST-1:0]   st_in_range_s;
  logic [N_LD-1:0]   ld_fire_s;
  logic [N_LD-1:0]   ld_in_range_s;
  logic [IDX_W-1:0]  st_idx_s [N_ST];
  logic [IDX_W-1:0]  ld_idx_s [N_LD];
  logic [DATA_W-1:0] ld_rd_s  [N_LD];
  logic              oob_hit_s;
  logic              unused_addr_s;

`ifdef HANDSHAKE_MEM_BOUNDS_CHECK_EN
  // DEPTH is a power of two, so "addr < DEPTH" means every bit above the index is zero.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    in_range = (addr[ADDR_W-1:IDX_W] == {(ADDR_W-IDX_W){1'b0}});
  endfunction
`endif

  // Address bits above the index only matter to the bounds check.
  assign unused_addr_s = ^{stAddr, ldAddr};

  assign stAddr_ready = st_fire_s;
  assign stData_ready = st_fire_s;
  assign ldAddr_ready = ~ldData_valid | ldData_ready;

  // Port handshakes, array indices and read-before-write load data.
  always_comb begin
    st_fire_s = stAddr_valid & stData_valid & (~stDone_valid | stDone_ready);
    ld_fire_s = ldAddr_valid & ldAddr_ready;
    for (int i = 0; i < N_ST; i++) begin
      st_idx_s[i] = stAddr[i*ADDR_W +: IDX_W];
`ifdef HANDSHAKE_MEM_BOUNDS_CHECK_EN
      st_in_range_s[i] = in_range(stAddr[i*ADDR_W +: ADDR_W]);
`else
      st_in_range_s[i] = 1'b1;
`endif
    end
    for (int j = 0; j < N_LD; j++) begin
      ld_idx_s[j] = ldAddr[j*ADDR_W +: IDX_W];
`ifdef HANDSHAKE_MEM_BOUNDS_CHECK_EN
      ld_in_range_s[j] = in_range(ldAddr[j*ADDR_W +: ADDR_W]);
`else
      ld_in_range_s[j] = 1'b1;
`endif
      if (ld_in_range_s[j]) begin
        ld_rd_s[j] = mem_r[ld_idx_s[j]];
      end else begin
        ld_rd_s[j] = {DATA_W{1'b0}};
      end
    end
    oob_hit_s = (|(st_fire_s & ~st_in_range_s)) | (|(ld_fire_s & ~ld_in_range_s));
  end

  // Array writes; descending scan so the lowest port index lands last and wins a collision.
  always_ff @(posedge clock) begin
    for (int i = N_ST-1; i >= 0; i--) begin
      if (!reset && st_fire_s[i] && st_in_range_s[i]) begin
        mem_r[st_idx_s[i]] <= stData[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-entry completion-token buffer per store port.
  always_ff @(posedge clock) begin
    if (reset) begin
      stDone_valid <= {N_ST{1'b0}};
    end else begin
      stDone_valid <= st_fire_s | (stDone_valid & ~stDone_ready);
    end
  end

  // One-entry load result buffer per load port; data held while valid and not ready.
  always_ff @(posedge clock) begin
    for (int j = 0; j < N_LD; j++) begin
      if (reset) begin
        ldData_valid[j]              <= 1'b0;
        ldData[j*DATA_W +: DATA_W]   <= {DATA_W{1'b0}};
      end else if (ld_fire_s[j]) begin
        ldData_valid[j]              <= 1'b1;
        ldData[j*DATA_W +: DATA_W]   <= ld_rd_s[j];
      end else if (ldData_ready[j]) begin
        ldData_valid[j]              <= 1'b0;
      end else begin
        ldData_valid[j]              <= ldData_valid[j];
      end
    end
  end

  // Sticky out-of-range flag; never sets when the bounds check is compiled out.
  always_ff @(posedge clock) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else begin
      oob_err <= oob_err | oob_hit_s;
    end
  end

endmodule

// File: tb/tb_handshake_memory_rw.sv
// Self-checking bench for handshake_memory_rw: load results go through a per-port expected queue.
module tb_handshake_memory_rw;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int DEPTH  = 4;
  localparam int N_ST   = 5;
  localparam int N_LD   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N_ST*DATA_W-1:0] stData;
  logic [N_ST-1:0]        stData_valid, stData_ready;
  logic [N_ST*ADDR_W-1:0] stAddr;
  logic [N_ST-1:0]        stAddr_valid, stAddr_ready;
  logic [N_ST-1:0]        stDone_valid, stDone_ready;
  logic [N_LD*ADDR_W-1:0] ldAddr;
  logic [N_LD-1:0]        ldAddr_valid, ldAddr_ready;
  logic [N_LD*DATA_W-1:0] ldData;
  logic [N_LD-1:0]        ldData_valid, ldData_ready;
  logic                   oob_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [N_LD][$];
  logic [DATA_W-1:0] mon_e;

  always #5 clock = ~clock;

  handshake_memory_rw #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .N_ST(N_ST), .N_LD(N_LD)) dut (
    .clock(clock), .reset(reset),
    .stData(stData), .stData_valid(stData_valid), .stData_ready(stData_ready),
    .stAddr(stAddr), .stAddr_valid(stAddr_valid), .stAddr_ready(stAddr_ready),
    .stDone_valid(stDone_valid), .stDone_ready(stDone_ready),
    .ldAddr(ldAddr), .ldAddr_valid(ldAddr_valid), .ldAddr_ready(ldAddr_ready),
    .ldData(ldData), .ldData_valid(ldData_valid), .ldData_ready(ldData_ready),
    .oob_err(oob_err)
  );

  // Scoreboard: every completed load transfer must match the oldest expected value for its port.
  always @(negedge clock) begin
    if (!reset) begin
      for (int j = 0; j < N_LD; j++) begin
        if (ldData_valid[j] && ldData_ready[j]) begin
          checks++;
          if (exp_q[j].size() == 0) begin
            errors++;
            $display("FAIL ld_unexpected port %0d got %h exp none", j, ldData[j*DATA_W +: DATA_W]);
          end else begin
            mon_e = exp_q[j].pop_front();
            if (ldData[j*DATA_W +: DATA_W] !== mon_e) begin
              errors++;
              $display("FAIL ld_data port %0d got %h exp %h", j, ldData[j*DATA_W +: DATA_W], mon_e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stData = '0; stData_valid = '0; stAddr = '0; stAddr_valid = '0; stDone_ready = '1;
    ldAddr = '0; ldAddr_valid = '0; ldData_ready = '1;
  endtask

  task automatic drive_st(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    stAddr[i*ADDR_W +: ADDR_W] = a;
    stData[i*DATA_W +: DATA_W] = d;
    stAddr_valid[i] = 1'b1;
    stData_valid[i] = 1'b1;
  endtask

  task automatic drive_ld(input int j, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    ldAddr[j*ADDR_W +: ADDR_W] = a;
    ldAddr_valid[j] = 1'b1;
    exp_q[j].push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); tick(); tick();
    @(negedge clock);
    checks++; if (stDone_valid !== 5'b00000) begin errors++; $display("FAIL rst_done got %b exp %b", stDone_valid, 5'b00000); end
    checks++; if (ldData_valid !== 2'b00) begin errors++; $display("FAIL rst_ldv got %b exp %b", ldData_valid, 2'b00); end
    checks++; if (ldData !== 128'h0) begin errors++; $display("FAIL rst_ldd got %h exp 0", ldData); end
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL rst_oob got %b exp 0", oob_err); end
    checks++; if (ldAddr_ready !== 2'b11) begin errors++; $display("FAIL rst_ldrdy got %b exp 11", ldAddr_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    drive_st(0, 64'd2, 64'hAAAA);
    @(negedge clock);
    checks++; if (stAddr_ready !== 5'b00001 || stData_ready !== 5'b00001) begin errors++; $display("FAIL sl_st_rdy got %b/%b exp 00001", stAddr_ready, stData_ready); end
    tick(); idle();
    drive_ld(0, 64'd2, 64'hAAAA);
    @(negedge clock);
    checks++; if (stDone_valid !== 5'b00001) begin errors++; $display("FAIL sl_token got %b exp 00001", stDone_valid); end
    checks++; if (ldData_valid !== 2'b00) begin errors++; $display("FAIL sl_ldv_early got %b exp 00", ldData_valid); end
    tick(); idle();
    @(negedge clock);
    checks++; if (stDone_valid !== 5'b00000) begin errors++; $display("FAIL sl_token_once got %b exp 00000", stDone_valid); end
    checks++; if (ldData_valid !== 2'b01) begin errors++; $display("FAIL sl_ldv got %b exp 01", ldData_valid); end
    tick();
  endtask

  task automatic test_collision();
    drive_st(0, 64'd1, 64'h11); drive_st(1, 64'd1, 64'h22); drive_st(4, 64'd1, 64'h55);
    @(negedge clock);
    checks++; if (stAddr_ready !== 5'b10011) begin errors++; $display("FAIL col_rdy got %b exp 10011", stAddr_ready); end
    tick(); idle();
    drive_ld(1, 64'd1, 64'h11);
    @(negedge clock);
    checks++; if (stDone_valid !== 5'b10011) begin errors++; $display("FAIL col_tokens got %b exp 10011", stDone_valid); end
    tick(); idle();
    @(negedge clock);
    checks++; if (ldData_valid !== 2'b10) begin errors++; $display("FAIL col_ldv got %b exp 10", ldData_valid); end
    tick();
  endtask

  task automatic test_join();
    drive_st(0, 64'd0, 64'h0F);
    tick(); idle();
    stAddr[3*ADDR_W +: ADDR_W] = 64'd0; stAddr_valid[3] = 1'b1;
    stData[3*DATA_W +: DATA_W] = 64'h33; stData_valid[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) drive_ld(0, 64'd0, 64'h0F);
      @(negedge clock);
      checks++; if (stAddr_ready[3] !== 1'b0 || stDone_valid[3] !== 1'b0) begin errors++; $display("FAIL join_hold%0d got rdy %b done %b exp 0 0", k, stAddr_ready[3], stDone_valid[3]); end
      tick();
    end
    ldAddr_valid = '0;
    stData[3*DATA_W +: DATA_W] = 64'h44; stData_valid[3] = 1'b1;
    @(negedge clock);
    checks++; if (stAddr_ready[3] !== 1'b1 || stData_ready[3] !== 1'b1) begin errors++; $display("FAIL join_fire got %b/%b exp 1/1", stAddr_ready[3], stData_ready[3]); end
    tick(); idle();
    @(negedge clock);
    checks++; if (stDone_valid[3] !== 1'b1) begin errors++; $display("FAIL join_token got %b exp 1", stDone_valid[3]); end
    tick();
    drive_ld(0, 64'd0, 64'h44);
    @(negedge clock);
    checks++; if (stDone_valid[3] !== 1'b0) begin errors++; $display("FAIL join_token_once got %b exp 0", stDone_valid[3]); end
    tick(); idle(); tick();
  endtask

  task automatic test_backpressure();
    stDone_ready[2] = 1'b0;
    drive_st(2, 64'd0, 64'h66);
    @(negedge clock);
    checks++; if (stAddr_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_first got %b exp 1", stAddr_ready[2]); end
    tick();
    drive_st(2, 64'd1, 64'h77);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++; if (stAddr_ready[2] !== 1'b0 || stData_ready[2] !== 1'b0 || stDone_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got rdy %b/%b done %b exp 0/0 1", k, stAddr_ready[2], stData_ready[2], stDone_valid[2]); end
      tick();
    end
    stDone_ready[2] = 1'b1;
    @(negedge clock);
    checks++; if (stAddr_ready[2] !== 1'b1) begin errors++; $display("FAIL bp_drain_accept got %b exp 1", stAddr_ready[2]); end
    tick(); idle();
    drive_ld(0, 64'd1, 64'h77); drive_ld(1, 64'd0, 64'h66);
    @(negedge clock);
    checks++; if (stDone_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_token2 got %b exp 1", stDone_valid[2]); end
    tick(); idle();
    @(negedge clock);
    checks++; if (stDone_valid[2] !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", stDone_valid[2]); end
    tick();
  endtask

  task automatic test_rbw();
    drive_st(0, 64'd3, 64'h7);
    tick(); idle();
    drive_ld(0, 64'd3, 64'h7); drive_st(1, 64'd3, 64'h9);
    tick(); idle(); ldData_ready[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++; if (ldData_valid[0] !== 1'b1 || ldData[0 +: DATA_W] !== 64'h7) begin errors++; $display("FAIL rbw_hold%0d got v %b d %h exp 1 7", k, ldData_valid[0], ldData[0 +: DATA_W]); end
      checks++; if (ldAddr_ready[0] !== 1'b0) begin errors++; $display("FAIL rbw_ldrdy%0d got %b exp 0", k, ldAddr_ready[0]); end
      tick();
    end
    ldData_ready[0] = 1'b1;
    drive_ld(0, 64'd3, 64'h9);
    @(negedge clock);
    checks++; if (ldAddr_ready[0] !== 1'b1) begin errors++; $display("FAIL rbw_reload got %b exp 1", ldAddr_ready[0]); end
    tick(); idle(); tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e [4];
    e[0] = 64'h66; e[1] = 64'h77; e[2] = 64'hAAAA; e[3] = 64'h9;
    for (int k = 0; k < 4; k++) begin
      drive_ld(1, 64'(k), e[k]);
      @(negedge clock);
      checks++; if (ldAddr_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got %b exp 1", k, ldAddr_ready[1]); end
      if (k > 0) begin
        checks++; if (ldData_valid[1] !== 1'b1) begin errors++; $display("FAIL b2b_ldv%0d got %b exp 1", k, ldData_valid[1]); end
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_oob();
    drive_st(0, 64'd6, 64'hBEEF);
    tick(); idle();
`ifdef HANDSHAKE_MEM_BOUNDS_CHECK_EN
    drive_ld(1, 64'd2, 64'hAAAA); drive_ld(0, 64'd6, 64'h0);
`else
    drive_ld(1, 64'd2, 64'hBEEF); drive_ld(0, 64'd6, 64'hBEEF);
`endif
    @(negedge clock);
    checks++; if (stDone_valid[0] !== 1'b1) begin errors++; $display("FAIL oob_token got %b exp 1", stDone_valid[0]); end
`ifdef HANDSHAKE_MEM_BOUNDS_CHECK_EN
    checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_flag got %b exp 1", oob_err); end
`else
    checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL oob_flag got %b exp 0", oob_err); end
`endif
    tick(); idle(); tick();
  endtask

  task automatic test_reset_mid();
    stDone_ready[0] = 1'b0; drive_st(0, 64'd0, 64'h5A);
    ldData_ready[1] = 1'b0; ldAddr[1*ADDR_W +: ADDR_W] = 64'd1; ldAddr_valid[1] = 1'b1;
    tick(); idle();
    stDone_ready[0] = 1'b0; ldData_ready[1] = 1'b0;
    reset = 1'b1; drive_st(1, 64'd1, 64'hDEAD);
    @(negedge clock);
    checks++; if (stDone_valid[0] !== 1'b1 || ldData_valid[1] !== 1'b1) begin errors++; $display("FAIL rm_pending got %b/%b exp 1/1", stDone_valid[0], ldData_valid[1]); end
    tick(); reset = 1'b0; idle();
    drive_ld(0, 64'd1, 64'h77); drive_ld(1, 64'd0, 64'h5A);
    @(negedge clock);
    checks++; if (stDone_valid !== 5'b00000 || ldData_valid !== 2'b00) begin errors++; $display("FAIL rm_clear got %b/%b exp 0/0", stDone_valid, ldData_valid); end
    checks++; if (ldData !== 128'h0 || oob_err !== 1'b0) begin errors++; $display("FAIL rm_regs got %h/%b exp 0/0", ldData, oob_err); end
    tick(); idle(); tick(); tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_store_load();
    test_collision();
    test_join();
    test_backpressure();
    test_rbw();
    test_back_to_back();
    test_oob();
    test_reset_mid();
    for (int j = 0; j < N_LD; j++) begin
      checks++;
      if (exp_q[j].size() != 0) begin
        errors++;
        $display("FAIL ld_missing port %0d got %0d outstanding exp 0", j, exp_q[j].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_memory_rw.md
# handshake_memory_rw

Parametrised handshake memory with N_ST store ports and N_LD load ports, each on elastic valid/ready channels, sitting between the dataflow datapath and a small on-chip array. Every accepted store writes on the next clock edge and returns a zero-width completion token. Every accepted load returns its data one cycle later through a one-entry output buffer. Same-cycle collisions and ordering are resolved deterministically.

## Interface
- DATA_W, 64, data width of stores and loads
- ADDR_W, 64, address width on every port
- DEPTH, 4, word count; must be a power of two, >= 2; IDX_W = $clog2(DEPTH)
- N_ST, 5, store port count (>= 1)
- N_LD, 2, load port count (>= 1)

Ports (flattened buses, port i occupies slice [i*W +: W]):
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- stData / stData_valid / stData_ready  in/in/out  N_ST*DATA_W / N_ST / N_ST  store data channels
- stAddr / stAddr_valid / stAddr_ready  in/in/out  N_ST*ADDR_W / N_ST / N_ST  store address channels
- stDone_valid / stDone_ready  out/in  N_ST / N_ST  store completion tokens (zero-width payload)
- ldAddr / ldAddr_valid / ldAddr_ready  in/in/out  N_LD*ADDR_W / N_LD / N_LD  load address channels
- ldData / ldData_valid / ldData_ready  out/out/in  N_LD*DATA_W / N_LD / N_LD  load data channels
- oob_err  out  1  sticky out-of-range flag (see Configuration)

## Operation
- Store join: for port i, st_fire[i] = stAddr_valid[i] & stData_valid[i] & done_free[i]. Here done_free[i] = ~stDone_valid[i] | stDone_ready[i]. stAddr_ready[i] = stData_ready[i] = st_fire[i]. A channel that is valid alone is never consumed.
- Write: on st_fire[i], mem[stAddr[i][IDX_W-1:0]] <= stData[i] at the edge. Writes happen only on fire, never on valid alone.
- Write collision: when several ports fire to the same index in one cycle, the lowest port index wins. The other ports still complete and still get tokens.
- Done buffer, per store port, 1 bit: next = st_fire[i] ? 1 : (stDone_ready[i] ? 0 : stDone_valid[i]).
- Load: ld_fire[j] = ldAddr_valid[j] & ldAddr_ready[j]. ldAddr_ready[j] = ~ldData_valid[j] | ldData_ready[j].
- On ld_fire[j], the ldData[j] register <= mem[ldAddr[j][IDX_W-1:0]] and ldData_valid[j] <= 1.
- Otherwise ldData_valid[j] clears when ldData_ready[j] is high. The data is held stable while valid & ~ready.
- Read/write ordering: a load firing in the same cycle as a store to the same index returns the old value (read-before-write).
- Array contents are not reset.

## Timing
- Reset values: stDone_valid = 0, ldData_valid = 0, ldData = 0, oob_err = 0. All readies follow from these registers and the current inputs.
- Reset asserted mid-operation: pending tokens and load results are discarded on the next edge, and no write occurs in a reset cycle. Array contents are retained.
- Store: accept in cycle t, write visible to loads accepted in t+1 or later, stDone_valid high in t+1.
- Load: accept in cycle t, ldData_valid in t+1. Throughput is 1/cycle/port when the consumer is ready.
- Store throughput is 1/cycle/port while stDone_ready stays high. With stDone_ready low and a token pending, the port stalls.
- No combinational path from any *_valid input to stDone_valid or ldData_valid.

## Configuration
- HANDSHAKE_MEM_BOUNDS_CHECK_EN defined: an address counts as out of range when it is >= DEPTH over the full ADDR_W.
  - Out-of-range stores are dropped (no write) but still produce a stDone token.
  - Out-of-range loads return 0.
  - oob_err sets on the edge after any such fire and stays set until reset.
- Macro undefined: addresses are truncated to IDX_W (modulo DEPTH) and oob_err is tied to 0.

## Test plan
- Reset, then store 0xAAAA to addr 2 on port 0 with stDone_ready=1 -> stDone_valid[0] high exactly 1 cycle. A load of addr 2 next cycle -> ldData=0xAAAA one cycle after accept.
- Ports 0, 1 and 4 store 0x11/0x22/0x55 to addr 1 in the same cycle -> all three tokens asserted, a later load of addr 1 returns 0x11.
- Port 3 with stAddr_valid=1 and stData_valid=0 for 3 cycles -> stAddr_ready=0, no write. Raise stData_valid -> exactly one write and one token.
- stDone_ready[2]=0 after a store -> the port-2 readies stay low and a second store stalls. Raise ready -> the token drains and the second store is accepted in the same cycle.
- Load and store to addr 3 in the same cycle (old 0x7, new 0x9) -> the load returns 0x7. Then hold ldData_ready=0 for 2 cycles -> data stable, ldAddr_ready low.
- Store to addr 6 with DEPTH=4 -> with macro: no write, token issued, oob_err=1 next cycle. Without macro: addr 2 is written, oob_err stays 0.
